// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, FSM state type and lane/size helpers
// used by the boot RAM slave.
//   HTRANS_* : transfer type encodings
//   HSIZE_*  : transfer size encodings (byte/half/word only are legal here)
//   HRESP_*  : response encodings
//   lane_mask()     : little-endian byte-lane enables for (hsize, haddr[1:0])
//   size_align_err(): illegal size or misaligned half/word
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [2:0] hsize,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic size_align_err(input logic [2:0] hsize,
                                          input logic [1:0] addr_lo);
    return (hsize > HSIZE_WORD) ||
           ((hsize == HSIZE_HALF) && addr_lo[0]) ||
           ((hsize == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_lite_boot_ram_if.sv
// ahb_lite_boot_ram_if: AHB-Lite slave-port bundle.
//   master modport : drives address/control/write data and bus-level hready,
//                    observes hreadyout/hresp/hrdata
//   slave modport  : the reverse
interface ahb_lite_boot_ram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans,
           hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans,
           hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/sram_1r1w_be.sv
// sram_1r1w_be: 2^ADDR_WIDTH x 32 synchronous RAM, one read port, one write
// port with 4 byte enables. Read data is registered and only updates when
// re_i is high; a same-address read/write on one edge returns the old word.
//   clk               : clock
//   re_i, raddr_i     : read enable / word address
//   rdata_o           : registered read data
//   we_i, waddr_i     : write enable / word address
//   be_i, wdata_i     : byte enables / write data
module sram_1r1w_be #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_lite_boot_ram.sv
// ahb_lite_boot_ram: AHB-Lite SRAM slave (2^ADDR_WIDTH words) shared by the
// SPI boot loader and the core. Pipelined address/data phases, byte/half
// lanes, WAIT_STATES extra wait cycles per OKAY data phase, two-cycle ERROR.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : AHB-Lite slave port (ahb_lite_boot_ram_if.slave)
module ahb_lite_boot_ram
  import ahb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 13,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic                 clk,
  input logic                 reset,
  ahb_lite_boot_ram_if.slave  bus
);

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            lanes_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [31:0]           hrdata_q;
  logic [3:0]            byp_mask_q;
  logic [31:0]           byp_data_q;

  logic                  accept, addr_err, data_done, can_start;
  logic                  go_data, go_err, wr_commit, rd_done, raw_hit;
  logic [ADDR_WIDTH-1:0] new_idx;
  logic [31:0]           ram_rdata, merged;

  assign accept  = bus.hsel & bus.hready & bus.htrans[1];
  assign new_idx = bus.haddr[ADDR_WIDTH+1:2];
  // Range check uses every bit above the word index, so aliases of the RAM
  // outside the window are rejected rather than wrapped.
  assign addr_err = size_align_err(bus.hsize, bus.haddr[1:0]) ||
                    (bus.haddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);

  assign data_done = (state_q == ST_DATA) && (cnt_q == 3'd0);
  assign can_start = (state_q == ST_IDLE) || (state_q == ST_ERR2) || data_done;
  assign go_data   = can_start & accept & ~addr_err;
  assign go_err    = can_start & accept & addr_err;
  assign wr_commit = data_done & wr_q;
  assign rd_done   = data_done & ~wr_q;
  // A read accepted on the edge that commits a write to the same word sees
  // stale RAM output; capture the write lanes so its data phase can merge.
  assign raw_hit   = wr_commit && (idx_q == new_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      lanes_q     <= 4'b0000;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= 32'h0;
      byp_mask_q  <= 4'b0000;
      byp_data_q  <= 32'h0;
    end else begin
      if (rd_done) hrdata_q <= merged;
      if (can_start) begin
        if (go_data) begin
          state_q     <= ST_DATA;
          cnt_q       <= 3'(WAIT_STATES);
          wr_q        <= bus.hwrite;
          idx_q       <= new_idx;
          lanes_q     <= lane_mask(bus.hsize, bus.haddr[1:0]);
          hreadyout_q <= (WAIT_STATES == 0);
          hresp_q     <= HRESP_OKAY;
          byp_mask_q  <= raw_hit ? lanes_q : 4'b0000;
          byp_data_q  <= bus.hwdata;
        end else if (go_err) begin
          state_q     <= ST_ERR1;
          wr_q        <= 1'b0;
          hreadyout_q <= 1'b0;
          hresp_q     <= HRESP_ERROR;
        end else begin
          state_q     <= ST_IDLE;
          wr_q        <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      end else if (state_q == ST_DATA) begin
        cnt_q       <= cnt_q - 3'd1;
        hreadyout_q <= (cnt_q == 3'd1);
      end else begin
        // ERR1: second response cycle drives ready high with ERROR held
        state_q     <= ST_ERR2;
        hreadyout_q <= 1'b1;
        hresp_q     <= HRESP_ERROR;
      end
    end
  end

  sram_1r1w_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .re_i    (go_data & ~bus.hwrite),
    .raddr_i (new_idx),
    .rdata_o (ram_rdata),
    .we_i    (wr_commit),
    .waddr_i (idx_q),
    .be_i    (lanes_q),
    .wdata_i (bus.hwdata)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = byp_mask_q[gi] ? byp_data_q[8*gi +: 8]
                                              : ram_rdata[8*gi +: 8];
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = rd_done ? merged : hrdata_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

endmodule

// File: tb/tb_ahb_lite_boot_ram.sv
module tb_ahb_lite_boot_ram;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ahb_lite_boot_ram_if bus0();
  ahb_lite_boot_ram_if bus3();
  assign bus0.hready = bus0.hreadyout;
  assign bus3.hready = bus3.hreadyout;

  ahb_lite_boot_ram #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  ahb_lite_boot_ram #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st0();
    return {30'd0, bus0.hreadyout, bus0.hresp};
  endfunction

  task automatic drive0(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bus0.hsel   = sel;
    bus0.htrans = tr;
    bus0.hwrite = wr;
    bus0.haddr  = a;
    bus0.hsize  = sz;
    bus0.hwdata = wd;
  endtask

  task automatic idle0(input logic [31:0] wd);
    drive0(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, wd);
  endtask

  task automatic wr0(input string tag, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] d);
    drive0(1'b1, HTRANS_NONSEQ, 1'b1, a, sz, 32'h0);
    tick();
    idle0(d);
    @(negedge clk);
    check({tag, " status"}, st0(), 32'h2);
    tick();
  endtask

  task automatic rd0(input string tag, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] exp);
    drive0(1'b1, HTRANS_NONSEQ, 1'b0, a, sz, 32'h0);
    tick();
    idle0(32'h0);
    @(negedge clk);
    check({tag, " status"}, st0(), 32'h2);
    check({tag, " data"}, bus0.hrdata, exp);
    tick();
  endtask

  task automatic xfer3(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    int lows;
    bus3.hsel = 1'b1; bus3.htrans = HTRANS_NONSEQ; bus3.hwrite = wr;
    bus3.haddr = a; bus3.hsize = HSIZE_WORD; bus3.hwdata = 32'h0;
    tick();
    bus3.hsel = 1'b0; bus3.htrans = HTRANS_IDLE; bus3.hwrite = 1'b0;
    bus3.hwdata = d;
    lows = 0;
    @(negedge clk);
    while (!bus3.hreadyout && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    check({tag, " waits"}, 32'(lows), 32'd3);
    if (!wr) check({tag, " data"}, bus3.hrdata, d);
    tick();
  endtask

  initial begin
    bus0.hburst = 3'b000; bus0.hprot = 4'b0011; bus0.hmastlock = 1'b0;
    bus3.hburst = 3'b000; bus3.hprot = 4'b0011; bus3.hmastlock = 1'b0;
    idle0(32'h0);
    bus3.hsel = 1'b0; bus3.htrans = HTRANS_IDLE; bus3.hwrite = 1'b0;
    bus3.haddr = 32'h0; bus3.hsize = HSIZE_WORD; bus3.hwdata = 32'h0;

    // reset state
    @(negedge clk);
    check("reset status", st0(), 32'h2);
    check("reset hrdata", bus0.hrdata, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // loader word writes and read-back
    wr0("ldr wr 200", 32'h200, HSIZE_WORD, 32'hDEADBEEF);
    wr0("ldr wr 204", 32'h204, HSIZE_WORD, 32'h12345678);
    rd0("ldr rd 200", 32'h200, HSIZE_WORD, 32'hDEADBEEF);
    rd0("ldr rd 204", 32'h204, HSIZE_WORD, 32'h12345678);

    // byte / half lanes
    wr0("wr 200", 32'h200, HSIZE_WORD, 32'h11223344);
    wr0("byte wr 201", 32'h201, HSIZE_BYTE, 32'h0000AA00);
    rd0("rd after byte", 32'h200, HSIZE_WORD, 32'h1122AA44);
    wr0("half wr 202", 32'h202, HSIZE_HALF, 32'hBEEF0000);
    rd0("rd after half", 32'h200, HSIZE_WORD, 32'hBEEFAA44);

    // BUSY with hsel: no access, OKAY, hrdata held
    drive0(1'b1, HTRANS_BUSY, 1'b0, 32'h204, HSIZE_WORD, 32'h0);
    tick();
    idle0(32'h0);
    @(negedge clk);
    check("busy status", st0(), 32'h2);
    check("busy hrdata hold", bus0.hrdata, 32'hBEEFAA44);
    tick();

    // back-to-back write then read of same word (bypass)
    drive0(1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h0);
    tick();
    drive0(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b wr status", st0(), 32'h2);
    tick();
    idle0(32'h0);
    @(negedge clk);
    check("b2b rd data", bus0.hrdata, 32'hCAFEF00D);
    tick();
    rd0("rd 10 committed", 32'h10, HSIZE_WORD, 32'hCAFEF00D);

    wr0("clr 10", 32'h10, HSIZE_WORD, 32'h0);
    drive0(1'b1, HTRANS_NONSEQ, 1'b1, 32'h13, HSIZE_BYTE, 32'h0);
    tick();
    drive0(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h55000000);
    tick();
    idle0(32'h0);
    @(negedge clk);
    check("b2b byte rd data", bus0.hrdata, 32'h55000000);
    tick();

    // errors: misaligned word write
    wr0("wr 0", 32'h0, HSIZE_WORD, 32'h13579BDF);
    drive0(1'b1, HTRANS_NONSEQ, 1'b1, 32'h202, HSIZE_WORD, 32'h0);
    tick();
    idle0(32'hFFFFFFFF);
    @(negedge clk);
    check("misalign err1", st0(), 32'h1);
    tick();
    @(negedge clk);
    check("misalign err2", st0(), 32'h3);
    tick();
    rd0("rd 200 after err", 32'h200, HSIZE_WORD, 32'hBEEFAA44);

    // out-of-range write; new read issued in ERR2
    drive0(1'b1, HTRANS_NONSEQ, 1'b1, 32'h8000, HSIZE_WORD, 32'h0);
    tick();
    idle0(32'hFFFFFFFF);
    @(negedge clk);
    check("range err1", st0(), 32'h1);
    tick();
    drive0(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'hFFFFFFFF);
    @(negedge clk);
    check("range err2", st0(), 32'h3);
    tick();
    idle0(32'h0);
    @(negedge clk);
    check("rd in err2 status", st0(), 32'h2);
    check("rd in err2 data", bus0.hrdata, 32'h13579BDF);
    tick();

    // illegal hsize
    drive0(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0, 3'b011, 32'h0);
    tick();
    idle0(32'h0);
    @(negedge clk);
    check("hsize err1", st0(), 32'h1);
    tick();
    @(negedge clk);
    check("hsize err2", st0(), 32'h3);
    tick();

    // reset during write data phase
    wr0("wr 40", 32'h40, HSIZE_WORD, 32'h0);
    drive0(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h0);
    tick();
    idle0(32'hFFFFFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle0(32'h0);
    @(negedge clk);
    check("post-reset status", st0(), 32'h2);
    check("post-reset hrdata", bus0.hrdata, 32'h0);
    tick();
    rd0("rd 40 after reset", 32'h40, HSIZE_WORD, 32'h0);

    // WAIT_STATES=3 instance
    xfer3("ws3 wr 100", 1'b1, 32'h100, 32'hA5A55A5A);
    xfer3("ws3 rd 100", 1'b0, 32'h100, 32'hA5A55A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
